// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous-read memory between a CPU port and a DMA port.
// Optional build macro ARB_LOCK_EN adds cpu_lock to keep ownership with the CPU.
module mem_port_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
`ifdef ARB_LOCK_EN
   input  logic              cpu_lock,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner_dma;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wait_cnt;
   logic              w_lock;
   logic              w_dma_win;
   logic              w_cpu_win;

   always_comb begin
      w_lock = 1'b0;
`ifdef ARB_LOCK_EN
      w_lock = cpu_lock && !r_owner_dma;
`endif
      w_dma_win   = (r_state == S_IDLE) && dma_req && !w_lock &&
                    (!cpu_req || (r_wait_cnt == LP_MAX_WAIT));
      w_cpu_win   = (r_state == S_IDLE) && cpu_req && !w_dma_win;
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_dma_win || w_cpu_win) w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = r_wr ? S_IDLE : S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_owner_dma <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wait_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_dma_win || w_cpu_win) begin
            r_owner_dma <= w_dma_win;
            r_wr        <= w_dma_win ? dma_wr    : cpu_wr;
            r_addr      <= w_dma_win ? dma_addr  : cpu_addr;
            r_wdata     <= w_dma_win ? dma_wdata : cpu_wdata;
         end
         // Starvation count only advances when the DMA actually lost a contested decision.
         if (w_dma_win)
            r_wait_cnt <= '0;
         else if (w_cpu_win && dma_req && (r_wait_cnt != LP_MAX_WAIT))
            r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end

   always_comb begin
      cpu_gnt    = (r_state == S_ACCESS) && !r_owner_dma;
      dma_gnt    = (r_state == S_ACCESS) &&  r_owner_dma;
      cpu_rvalid = (r_state == S_RESP)   && !r_owner_dma;
      dma_rvalid = (r_state == S_RESP)   &&  r_owner_dma;
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      dma_rdata  = dma_rvalid ? mem_rdata : '0;
      mem_addr   = (r_state == S_ACCESS) ? r_addr  : '0;
      mem_wdata  = (r_state == S_ACCESS) ? r_wdata : '0;
      mem_rd     = (r_state == S_ACCESS) && !r_wr;
      mem_wr     = (r_state == S_ACCESS) &&  r_wr;
      busy       = (r_state != S_IDLE);
   end

endmodule
